// File: rtl/sdram_test_pkg.sv
// Shared definitions for the SDRAM test responder and the initiator side.
// Contents: address/data widths of the command interface, default latency
// constants, and the responder state enumeration.
package sdram_test_pkg;

    localparam int unsigned ADDR_W = 25;
    localparam int unsigned DATA_W = 16;

    localparam int unsigned DEF_MEM_ADDR_BITS    = 16;
    localparam int unsigned DEF_WRITE_LATENCY    = 2;
    localparam int unsigned DEF_READ_LATENCY     = 3;
    localparam int unsigned DEF_RECOVERY_CYCLES  = 1;
    localparam int unsigned DEF_INIT_CYCLES      = 16;
    localparam int unsigned DEF_REFRESH_INTERVAL = 1024;
    localparam int unsigned DEF_REFRESH_CYCLES   = 8;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_WRITE_WAIT,
        ST_READ_WAIT,
        ST_RECOVER,
        ST_REFRESH
    } state_e;

endpackage

// File: rtl/sdram_model_ram.sv
// Single-port synchronous block RAM standing in for the SDRAM array.
// Ports:
//   clk_i    clock
//   we_i     write enable (write at addr_i on the rising edge)
//   addr_i   word address, ADDR_BITS wide
//   wdata_i  write data
//   rdata_o  registered read data, one cycle after addr_i (read-first)
// Contents are not initialised.
module sdram_model_ram #(
    parameter int unsigned ADDR_BITS = 16,
    parameter int unsigned DATA_BITS = 16
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [ADDR_BITS-1:0] addr_i,
    input  logic [DATA_BITS-1:0] wdata_i,
    output logic [DATA_BITS-1:0] rdata_o
);

    logic [DATA_BITS-1:0] mem_q [2**ADDR_BITS];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_o <= mem_q[addr_i];
    end

endmodule

// File: rtl/sdram_test_responder.sv
// Target end of the SDRAM test command handshake. Accepts write/read
// commands, stores data in block RAM and returns read data with SDRAM-like
// latency, plus init and periodic refresh busy windows.
// Ports:
//   inputClock           clock
//   reset                synchronous, active-high
//   inputValid           command request, held until recievedCommand
//   isWriting            1 = write, 0 = read (sampled with inputValid)
//   inputAddress         25-bit word address (upper bits alias)
//   inputData            write data
//   faultEnable          flips bit 0 of read data at FAULT_ADDR
//   isBusy               1 = no new command accepted
//   recievedCommand      one-cycle pulse: command latched
//   outputDataAvailable  one-cycle pulse: outputData valid
//   outputData           read data, held until the next read return
// Write/read/recover waits count their latency starting the cycle after the
// state is entered; init and refresh windows are exactly their cycle count.
module sdram_test_responder
    import sdram_test_pkg::*;
#(
    parameter int unsigned       MEM_ADDR_BITS    = DEF_MEM_ADDR_BITS,
    parameter int unsigned       WRITE_LATENCY    = DEF_WRITE_LATENCY,
    parameter int unsigned       READ_LATENCY     = DEF_READ_LATENCY,
    parameter int unsigned       RECOVERY_CYCLES  = DEF_RECOVERY_CYCLES,
    parameter int unsigned       INIT_CYCLES      = DEF_INIT_CYCLES,
    parameter int unsigned       REFRESH_INTERVAL = DEF_REFRESH_INTERVAL,
    parameter int unsigned       REFRESH_CYCLES   = DEF_REFRESH_CYCLES,
    parameter logic [ADDR_W-1:0] FAULT_ADDR       = 25'd500
) (
    input  logic              inputClock,
    input  logic              reset,
    input  logic              inputValid,
    input  logic              isWriting,
    input  logic [ADDR_W-1:0] inputAddress,
    input  logic [DATA_W-1:0] inputData,
    input  logic              faultEnable,
    output logic              isBusy,
    output logic              recievedCommand,
    output logic              outputDataAvailable,
    output logic [DATA_W-1:0] outputData
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned REF_W = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [REF_W-1:0]  ref_cnt_q, ref_cnt_d;
    logic              pend_q, pend_d;
    logic              armed_q, armed_d;
    logic              busy_q, busy_d;
    logic              recv_q, recv_d;
    logic              avail_q, avail_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;
    logic              ref_set;
    logic              ref_clr;
    logic              fault_hit;

    sdram_model_ram #(
        .ADDR_BITS (MEM_ADDR_BITS),
        .DATA_BITS (DATA_W)
    ) u_ram (
        .clk_i   (inputClock),
        .we_i    (ram_we),
        .addr_i  (addr_q[MEM_ADDR_BITS-1:0]),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata)
    );

    assign fault_hit = faultEnable && (addr_q == FAULT_ADDR);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        ref_cnt_d = ref_cnt_q;
        armed_d   = armed_q;
        busy_d    = busy_q;
        recv_d    = 1'b0;
        avail_d   = 1'b0;
        data_d    = data_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        ram_we    = 1'b0;
        ref_set   = 1'b0;
        ref_clr   = 1'b0;

        // Free-running refresh timer, keeps counting through commands.
        if (REFRESH_INTERVAL != 0) begin
            if (ref_cnt_q == REF_W'(REFRESH_INTERVAL - 1)) begin
                ref_cnt_d = '0;
                ref_set   = 1'b1;
            end else begin
                ref_cnt_d = ref_cnt_q + 1'b1;
            end
        end

        // Re-arm only once the initiator has dropped its request.
        if (!inputValid) begin
            armed_d = 1'b1;
        end

        case (state_q)
            ST_INIT: begin
                busy_d = 1'b1;
                if (cnt_q == CNT_W'(INIT_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end
            end
            ST_IDLE: begin
                cnt_d = '0;
                if (pend_q) begin
                    state_d = ST_REFRESH;
                    busy_d  = 1'b1;
                    ref_clr = 1'b1;
                end else if (inputValid && armed_q) begin
                    state_d = isWriting ? ST_WRITE_WAIT : ST_READ_WAIT;
                    busy_d  = 1'b1;
                    recv_d  = 1'b1;
                    armed_d = 1'b0;
                    wr_d    = isWriting;
                    addr_d  = inputAddress;
                    wdata_d = inputData;
                end
            end
            ST_WRITE_WAIT: begin
                if (cnt_q == CNT_W'(WRITE_LATENCY)) begin
                    ram_we  = 1'b1;
                    state_d = ST_RECOVER;
                    cnt_d   = '0;
                end
            end
            ST_READ_WAIT: begin
                // RAM address is stable from entry, so the read word is ready well before exit.
                if (cnt_q == CNT_W'(READ_LATENCY)) begin
                    data_d  = ram_rdata ^ {{(DATA_W-1){1'b0}}, fault_hit};
                    avail_d = 1'b1;
                    state_d = ST_RECOVER;
                    cnt_d   = '0;
                end
            end
            ST_RECOVER: begin
                if (cnt_q == CNT_W'(RECOVERY_CYCLES)) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end
            end
            ST_REFRESH: begin
                if (cnt_q == CNT_W'(REFRESH_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_INIT;
                busy_d  = 1'b1;
                cnt_d   = '0;
            end
        endcase

        // A new request landing on the same edge as the clear must survive.
        pend_d = (pend_q && !ref_clr) || ref_set;
    end

    always_ff @(posedge inputClock) begin
        if (reset) begin
            state_q   <= ST_INIT;
            cnt_q     <= '0;
            ref_cnt_q <= '0;
            pend_q    <= 1'b0;
            armed_q   <= 1'b1;
            busy_q    <= 1'b1;
            recv_q    <= 1'b0;
            avail_q   <= 1'b0;
            data_q    <= '0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ref_cnt_q <= ref_cnt_d;
            pend_q    <= pend_d;
            armed_q   <= armed_d;
            busy_q    <= busy_d;
            recv_q    <= recv_d;
            avail_q   <= avail_d;
            data_q    <= data_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign isBusy              = busy_q;
    assign recievedCommand     = recv_q;
    assign outputDataAvailable = avail_q;
    assign outputData          = data_q;

endmodule

// File: tb/tb_sdram_test_responder.sv
// Randomised command traffic against sdram_test_responder with a
// transaction-timing reference model, plus directed literal checks for
// init timing, read latency, single acceptance, aliasing, fault injection
// and the refresh window.
module tb_sdram_test_responder;

    localparam int INIT_C = 16;
    localparam int WL     = 2;
    localparam int RL     = 3;
    localparam int REC    = 1;
    localparam int RI     = 32;
    localparam int RC     = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        inputValid = 1'b0;
    logic        isWriting = 1'b0;
    logic [24:0] inputAddress = '0;
    logic [15:0] inputData = '0;
    logic        faultEnable = 1'b0;
    logic        isBusy;
    logic        recievedCommand;
    logic        outputDataAvailable;
    logic [15:0] outputData;

    int checks = 0;
    int errors = 0;

    sdram_test_responder #(
        .REFRESH_INTERVAL (RI)
    ) dut (
        .inputClock          (clk),
        .reset               (reset),
        .inputValid          (inputValid),
        .isWriting           (isWriting),
        .inputAddress        (inputAddress),
        .inputData           (inputData),
        .faultEnable         (faultEnable),
        .isBusy              (isBusy),
        .recievedCommand     (recievedCommand),
        .outputDataAvailable (outputDataAvailable),
        .outputData          (outputData)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference model: edge e counts rising edges since reset release.
    // The responder is free (idle) once e > free_at; expectations describe
    // the outputs visible after edge e.
    int          e = 0;
    int          free_at = INIT_C;
    int          ret_edge = -1;
    bit          pend = 0;
    bit          armed = 1;
    bit          accepted;
    logic [24:0] ret_addr = '0;
    logic [15:0] mem [int];
    logic        exp_busy = 1'b1;
    logic        exp_recv = 1'b0;
    logic        exp_avail = 1'b0;
    logic [15:0] exp_data = '0;

    always @(posedge clk) begin
        if (reset) begin
            e = 0; free_at = INIT_C; ret_edge = -1; pend = 0; armed = 1;
            exp_busy = 1'b1; exp_recv = 1'b0; exp_avail = 1'b0; exp_data = '0;
        end else begin
            e++;
            exp_recv  = 1'b0;
            exp_avail = 1'b0;
            accepted  = 0;
            if (e == ret_edge) begin
                exp_avail = 1'b1;
                exp_data  = mem[int'(ret_addr[15:0])];
                if (faultEnable && ret_addr == 25'd500) exp_data[0] = ~exp_data[0];
            end
            if (e > free_at) begin
                if (pend) begin
                    pend    = 0;
                    free_at = e + RC;
                end else if (inputValid && armed) begin
                    accepted = 1;
                    exp_recv = 1'b1;
                    if (isWriting) begin
                        mem[int'(inputAddress[15:0])] = inputData;
                        free_at = e + WL + 1 + REC + 1;
                    end else begin
                        ret_addr = inputAddress;
                        ret_edge = e + RL + 1;
                        free_at  = ret_edge + REC + 1;
                    end
                end
            end
            if (!inputValid) armed = 1;
            if (accepted) armed = 0;
            if (e % RI == 0) pend = 1;
            exp_busy = (e < free_at);
        end
    end

    always @(negedge clk) begin
        chk("busy", 32'(isBusy), 32'(exp_busy));
        chk("recv", 32'(recievedCommand), 32'(exp_recv));
        chk("avail", 32'(outputDataAvailable), 32'(exp_avail));
        chk("data", 32'(outputData), 32'(exp_data));
    end

    task automatic do_cmd(input logic wr, input logic [24:0] a, input logic [15:0] d, input int hold,
                          output int rc_cyc, output int av_cyc, output int idle_cyc,
                          output logic [15:0] rd, output int n_recv);
        bit done;
        rc_cyc = -1; av_cyc = -1; idle_cyc = -1; rd = '0; n_recv = 0; done = 0;
        @(posedge clk); #1;
        inputValid = 1'b1; isWriting = wr; inputAddress = a; inputData = d;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (recievedCommand) begin
                n_recv++;
                if (rc_cyc < 0) rc_cyc = e;
            end
            if (outputDataAvailable && av_cyc < 0) begin
                av_cyc = e;
                rd = outputData;
            end
            if (rc_cyc >= 0 && !isBusy && (wr || av_cyc >= 0)) begin
                idle_cyc = e;
                done = 1;
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL cmd_timeout: addr %0h wr %0d never completed", a, wr);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (recievedCommand) n_recv++;
        end
        @(posedge clk); #1;
        inputValid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          rc, av, idl, nr;
        logic [15:0] rd;
        logic [15:0] wlist[$];
        logic [24:0] a;
        logic [15:0] lo;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", 32'(isBusy), 32'd1);
        chk("reset_recv", 32'(recievedCommand), 32'd0);
        chk("reset_avail", 32'(outputDataAvailable), 32'd0);
        chk("reset_data", 32'(outputData), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Boot: init window, then the first refresh while idle.
        while (e < 41) begin
            @(negedge clk);
            if (e == 15) chk("init_busy_e15", 32'(isBusy), 32'd1);
            if (e == 16) chk("init_idle_e16", 32'(isBusy), 32'd0);
            if (e == 33) chk("refresh_busy_e33", 32'(isBusy), 32'd1);
            if (e == 40) chk("refresh_busy_e40", 32'(isBusy), 32'd1);
            if (e == 41) chk("refresh_idle_e41", 32'(isBusy), 32'd0);
        end

        do_cmd(1'b1, 25'd5, 16'h0005, 0, rc, av, idl, rd, nr);
        wlist.push_back(16'd5);
        do_cmd(1'b0, 25'd5, 16'h0000, 10, rc, av, idl, rd, nr);
        chk("rd5_data", 32'(rd), 32'h0005);
        chk("rd5_pulse_latency", 32'(av - rc), 32'd4);
        chk("rd5_busy_fall", 32'(idl - av), 32'd2);
        chk("held_valid_single_accept", 32'(nr), 32'd1);

        do_cmd(1'b1, 25'h010007, 16'hBEEF, 0, rc, av, idl, rd, nr);
        wlist.push_back(16'd7);
        do_cmd(1'b0, 25'h000007, 16'h0000, 0, rc, av, idl, rd, nr);
        chk("alias_data", 32'(rd), 32'h0000BEEF);

        @(posedge clk); #1 faultEnable = 1'b1;
        do_cmd(1'b1, 25'd500, 16'd500, 0, rc, av, idl, rd, nr);
        wlist.push_back(16'd500);
        do_cmd(1'b0, 25'd500, 16'h0000, 0, rc, av, idl, rd, nr);
        chk("fault_on_data", 32'(rd), 32'h01F5);
        @(posedge clk); #1 faultEnable = 1'b0;
        do_cmd(1'b0, 25'd500, 16'h0000, 0, rc, av, idl, rd, nr);
        chk("fault_off_data", 32'(rd), 32'h01F4);

        for (int n = 0; n < 80; n++) begin
            repeat ($urandom_range(0, 4)) @(posedge clk);
            #1 faultEnable = ($urandom_range(0, 3) == 0);
            if (wlist.size() == 0 || $urandom_range(0, 1) == 1) begin
                a = 25'($urandom);
                if ($urandom_range(0, 7) == 0) a = 25'd500;
                do_cmd(1'b1, a, 16'($urandom), $urandom_range(0, 3), rc, av, idl, rd, nr);
                wlist.push_back(a[15:0]);
            end else begin
                lo = wlist[$urandom_range(0, wlist.size() - 1)];
                a = {9'($urandom), lo};
                if ($urandom_range(0, 1) == 1) a[24:16] = '0;
                do_cmd(1'b0, a, 16'h0000, $urandom_range(0, 3), rc, av, idl, rd, nr);
            end
            if (n % 10 == 0) chk("rand_single_accept", 32'(nr), 32'd1);
        end

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
